stage_mem: RTL and testbench

Memory-access pipeline stage between `regs_exemem` and `regs_memwb`. It consumes the EXE results: the address in `alures`, store data in `dmdin`, and the `memop` descriptor. It performs word, half and byte loads and stores over a req/ack data-memory bus and raises a stall request while an access is outstanding. Non-memory instructions, including the HI/LO write and multiply results, pass through with a one-cycle registered latency.

---
 rtl/mips_cpu_pkg.sv | 44 ++++
 rtl/mem_lsu_align.sv | 50 +++++
 rtl/stage_mem.sv | 172 +++++++++++++++++
 tb/tb_stage_mem.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS pipeline: data words, register names and the
// memory-stage descriptor, state and exception encodings.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] double_word_t;

    typedef enum logic [4:0] {
        REG_ZERO, REG_AT, REG_V0, REG_V1, REG_A0, REG_A1, REG_A2, REG_A3,
        REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
        REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_T8, REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
    } reg_enum;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } memsize_enum;

    typedef struct packed {
        logic        is_load;
        logic        is_store;
        memsize_enum size;
        logic        sign_ext;
    } memop_struct;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUS  = 1'b1
    } mem_state_enum;

    // Codes follow the MIPS Cause.ExcCode numbering for address errors
    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5
    } excode_enum;

    function automatic logic memop_is_mem(input memop_struct m);
        return m.is_load | m.is_store;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the memory stage: store alignment check,
// byte enables and data replication, and load lane extraction/extension.
module mem_lsu_align
    import mips_cpu_pkg::*;
(
    input  logic [1:0]  req_off,
    input  memsize_enum req_size,
    input  word_t       req_dmdin,
    output logic        req_aligned,
    output logic [3:0]  req_be,
    output word_t       req_wdata,
    input  logic [1:0]  rsp_off,
    input  memsize_enum rsp_size,
    input  logic        rsp_sign_ext,
    input  word_t       rsp_rdata,
    output word_t       rsp_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        req_aligned = 1'b1;
        req_be      = 4'b1111;
        req_wdata   = req_dmdin;
        case (req_size)
            MEM_B: begin
                req_be    = 4'b0001 << req_off;
                req_wdata = {4{req_dmdin[7:0]}};
            end
            MEM_H: begin
                req_aligned = ~req_off[0];
                req_be      = req_off[1] ? 4'b1100 : 4'b0011;
                req_wdata   = {2{req_dmdin[15:0]}};
            end
            default: req_aligned = (req_off == 2'b00);
        endcase
    end

    always_comb begin
        lane_b = rsp_rdata[{rsp_off, 3'b000} +: 8];
        lane_h = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        case (rsp_size)
            MEM_B:   rsp_data = {{24{rsp_sign_ext & lane_b[7]}}, lane_b};
            MEM_H:   rsp_data = {{16{rsp_sign_ext & lane_h[15]}}, lane_h};
            default: rsp_data = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: issues loads/stores on the req/ack bus,
// stalls upstream while an access is outstanding, registers results to MEM/WB.
//
// state   | meaning
// MS_IDLE | no access outstanding; non-memory results pass through
// MS_BUS  | dm_req held with latched address/data until dm_ack
module stage_mem
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               mem_i_valid,
    input  logic               mem_i_dm2rf,
    input  logic               mem_i_hilowe,
    input  logic               mem_i_rfwe,
    input  reg_enum            mem_i_rfwa,
    input  double_word_t       mem_i_mulres,
    input  word_t              mem_i_alures,
    input  word_t              mem_i_dmdin,
    input  memop_struct        mem_i_memop,
    output logic               mem_o_stallreq,
    output logic               dm_req,
    output logic               dm_we,
    output logic [3:0]         dm_be,
    output logic [ADDR_W-1:0]  dm_addr,
    output word_t              dm_wdata,
    input  logic               dm_ack,
    input  word_t              dm_rdata,
    output logic               mem_o_valid,
    output logic               mem_o_dm2rf,
    output logic               mem_o_hilowe,
    output logic               mem_o_rfwe,
    output reg_enum            mem_o_rfwa,
    output double_word_t       mem_o_mulres,
    output word_t              mem_o_wbdata,
    output excode_enum         mem_o_excode
);

    mem_state_enum state_q, state_d;
    logic          is_mem, aligned, misal, accept;
    logic [3:0]    be_in;
    word_t         wdata_in, ld_data;

    word_t         alures_q, wdata_q;
    logic [3:0]    be_q;
    logic          we_q, is_load_q, sign_ext_q;
    memsize_enum   size_q;
    logic          dm2rf_q, hilowe_q, rfwe_q;
    reg_enum       rfwa_q;
    double_word_t  mulres_q;

    mem_lsu_align u_align (
        .req_off      (mem_i_alures[1:0]),
        .req_size     (mem_i_memop.size),
        .req_dmdin    (mem_i_dmdin),
        .req_aligned  (aligned),
        .req_be       (be_in),
        .req_wdata    (wdata_in),
        .rsp_off      (alures_q[1:0]),
        .rsp_size     (size_q),
        .rsp_sign_ext (sign_ext_q),
        .rsp_rdata    (dm_rdata),
        .rsp_data     (ld_data)
    );

    assign is_mem = mem_i_valid & memop_is_mem(mem_i_memop);
    assign misal  = is_mem & ~aligned;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state_q <= MS_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        mem_o_stallreq = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (is_mem && aligned) begin
                    accept         = 1'b1;
                    mem_o_stallreq = 1'b1;
                    state_d        = MS_BUS;
                end
            end
            MS_BUS: begin
                mem_o_stallreq = ~dm_ack;
                if (dm_ack) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // dm_req comes straight from the state flop so reset drops it asynchronously
    assign dm_req   = (state_q == MS_BUS);
    assign dm_we    = we_q;
    assign dm_be    = be_q;
    assign dm_wdata = wdata_q;
    assign dm_addr  = {alures_q[ADDR_W-1:2], 2'b00};

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            alures_q   <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            sign_ext_q <= 1'b0;
            size_q     <= MEM_B;
            dm2rf_q    <= 1'b0;
            hilowe_q   <= 1'b0;
            rfwe_q     <= 1'b0;
            rfwa_q     <= REG_ZERO;
            mulres_q   <= '0;
        end else if (accept) begin
            alures_q   <= mem_i_alures;
            wdata_q    <= wdata_in;
            be_q       <= be_in;
            we_q       <= mem_i_memop.is_store;
            is_load_q  <= mem_i_memop.is_load;
            sign_ext_q <= mem_i_memop.sign_ext;
            size_q     <= mem_i_memop.size;
            dm2rf_q    <= mem_i_dm2rf;
            hilowe_q   <= mem_i_hilowe;
            rfwe_q     <= mem_i_rfwe;
            rfwa_q     <= mem_i_rfwa;
            mulres_q   <= mem_i_mulres;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mem_o_valid  <= 1'b0;
            mem_o_dm2rf  <= 1'b0;
            mem_o_hilowe <= 1'b0;
            mem_o_rfwe   <= 1'b0;
            mem_o_rfwa   <= REG_ZERO;
            mem_o_mulres <= '0;
            mem_o_wbdata <= '0;
            mem_o_excode <= EXC_NONE;
        end else if (state_q == MS_IDLE) begin
            if (accept) begin
                mem_o_valid  <= 1'b0;
                mem_o_dm2rf  <= 1'b0;
                mem_o_hilowe <= 1'b0;
                mem_o_rfwe   <= 1'b0;
            end else begin
                mem_o_valid  <= mem_i_valid;
                mem_o_dm2rf  <= mem_i_dm2rf & ~misal;
                mem_o_hilowe <= mem_i_hilowe & ~misal;
                mem_o_rfwe   <= mem_i_rfwe & ~misal;
                mem_o_rfwa   <= mem_i_rfwa;
                mem_o_mulres <= mem_i_mulres;
                mem_o_wbdata <= mem_i_alures;
                mem_o_excode <= !misal ? EXC_NONE :
                                mem_i_memop.is_load ? EXC_ADEL : EXC_ADES;
            end
        end else if (dm_ack) begin
            mem_o_valid  <= 1'b1;
            mem_o_dm2rf  <= dm2rf_q;
            mem_o_hilowe <= hilowe_q;
            mem_o_rfwe   <= rfwe_q;
            mem_o_rfwa   <= rfwa_q;
            mem_o_mulres <= mulres_q;
            mem_o_wbdata <= is_load_q ? ld_data : alures_q;
            mem_o_excode <= EXC_NONE;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed instruction stream, a per-cycle
// expectation model derived from the access rules, and literal spot checks.
`timescale 1ns/1ps
module tb_stage_mem;
    import mips_cpu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int NCYC   = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0, i_dm2rf = 1'b0, i_hilowe = 1'b0, i_rfwe = 1'b0;
    reg_enum      i_rfwa = REG_ZERO;
    double_word_t i_mulres = '0;
    word_t        i_alures = '0, i_dmdin = '0;
    memop_struct  i_memop = '0;
    logic         stallreq, dm_req, dm_we;
    logic [3:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    word_t        dm_wdata;
    logic         dm_ack = 1'b0;
    word_t        dm_rdata = '0;
    logic         o_valid, o_dm2rf, o_hilowe, o_rfwe;
    reg_enum      o_rfwa;
    double_word_t o_mulres;
    word_t        o_wbdata;
    excode_enum   o_excode;

    always #10 clk = ~clk;

    stage_mem #(.ADDR_W(ADDR_W)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .mem_i_valid(i_valid), .mem_i_dm2rf(i_dm2rf), .mem_i_hilowe(i_hilowe),
        .mem_i_rfwe(i_rfwe), .mem_i_rfwa(i_rfwa), .mem_i_mulres(i_mulres),
        .mem_i_alures(i_alures), .mem_i_dmdin(i_dmdin), .mem_i_memop(i_memop),
        .mem_o_stallreq(stallreq),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_o_valid(o_valid), .mem_o_dm2rf(o_dm2rf), .mem_o_hilowe(o_hilowe),
        .mem_o_rfwe(o_rfwe), .mem_o_rfwa(o_rfwa), .mem_o_mulres(o_mulres),
        .mem_o_wbdata(o_wbdata), .mem_o_excode(o_excode)
    );

    localparam memop_struct OP_NONE = '{is_load:1'b0, is_store:1'b0, size:MEM_W, sign_ext:1'b0};
    localparam memop_struct OP_LW   = '{is_load:1'b1, is_store:1'b0, size:MEM_W, sign_ext:1'b1};
    localparam memop_struct OP_LH   = '{is_load:1'b1, is_store:1'b0, size:MEM_H, sign_ext:1'b1};
    localparam memop_struct OP_LHU  = '{is_load:1'b1, is_store:1'b0, size:MEM_H, sign_ext:1'b0};
    localparam memop_struct OP_LB   = '{is_load:1'b1, is_store:1'b0, size:MEM_B, sign_ext:1'b1};
    localparam memop_struct OP_LBU  = '{is_load:1'b1, is_store:1'b0, size:MEM_B, sign_ext:1'b0};
    localparam memop_struct OP_SW   = '{is_load:1'b0, is_store:1'b1, size:MEM_W, sign_ext:1'b0};
    localparam memop_struct OP_SH   = '{is_load:1'b0, is_store:1'b1, size:MEM_H, sign_ext:1'b0};
    localparam memop_struct OP_SB   = '{is_load:1'b0, is_store:1'b1, size:MEM_B, sign_ext:1'b0};

    typedef struct {
        logic         valid, dm2rf, hilowe, rfwe;
        reg_enum      rfwa;
        double_word_t mulres;
        word_t        wbdata;
        excode_enum   excode;
    } out_t;

    out_t       exp_out  [NCYC];
    bit         exp_full [NCYC];
    bit         exp_stall[NCYC];
    bit         exp_req  [NCYC];
    bit         exp_we   [NCYC];
    logic [3:0] exp_be   [NCYC];
    word_t      exp_wdata[NCYC];
    word_t      exp_addr [NCYC];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit misaligned(input memop_struct m, input word_t a);
        if (m.size == MEM_H) return (a % 2) != 0;
        if (m.size == MEM_W) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic word_t load_model(input memop_struct m, input word_t a, input word_t rd);
        word_t lane;
        lane = rd >> (8 * (a % 4));
        if (m.size == MEM_B) begin
            lane = lane & 32'hFF;
            if (m.sign_ext) lane = (lane ^ 32'h80) - 32'h80;
        end else if (m.size == MEM_H) begin
            lane = lane & 32'hFFFF;
            if (m.sign_ext) lane = (lane ^ 32'h8000) - 32'h8000;
        end else begin
            lane = rd;
        end
        return lane;
    endfunction

    function automatic logic [3:0] be_model(input memop_struct m, input word_t a);
        if (m.size == MEM_B) return 4'(1 << (a % 4));
        if (m.size == MEM_H) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic word_t wdata_model(input memop_struct m, input word_t d);
        if (m.size == MEM_B) return (d & 32'hFF) * 32'h0101_0101;
        if (m.size == MEM_H) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    always @(negedge clk) begin : compare
        int c;
        c = cyc;
        if (chk_en && c < NCYC) begin
            check("stallreq", stallreq, exp_stall[c]);
            check("dm_req", dm_req, exp_req[c]);
            if (exp_req[c]) begin
                check("dm_we", dm_we, exp_we[c]);
                check("dm_be", dm_be, exp_be[c]);
                check("dm_addr", dm_addr, exp_addr[c]);
                check("dm_wdata", dm_wdata, exp_wdata[c]);
            end
            if (exp_full[c]) begin
                check("o_valid", o_valid, exp_out[c].valid);
                check("o_dm2rf", o_dm2rf, exp_out[c].dm2rf);
                check("o_hilowe", o_hilowe, exp_out[c].hilowe);
                check("o_rfwe", o_rfwe, exp_out[c].rfwe);
                check("o_rfwa", o_rfwa, exp_out[c].rfwa);
                check("o_mulres", o_mulres, exp_out[c].mulres);
                check("o_wbdata", o_wbdata, exp_out[c].wbdata);
                check("o_excode", o_excode, exp_out[c].excode);
            end else begin
                check("o_valid_idle", o_valid, 1'b0);
            end
        end
    end

    // Drives one instruction in the current cycle, records what the stage must
    // produce, plays the bus for k cycles if it is accepted, returns when the
    // next instruction may be presented.
    task automatic issue(input bit v, input memop_struct m, input word_t alu, input word_t din,
                         input bit rfwe, input bit dm2rf, input bit hilowe, input reg_enum wa,
                         input double_word_t mul, input int k, input word_t rd);
        int c;
        bit mem, bad;
        out_t o;
        c = cyc;
        i_valid = v; i_memop = m; i_alures = alu; i_dmdin = din;
        i_rfwe = rfwe; i_dm2rf = dm2rf; i_hilowe = hilowe; i_rfwa = wa; i_mulres = mul;
        mem = v && (m.is_load || m.is_store);
        bad = mem && misaligned(m, alu);
        o.valid = v; o.rfwa = wa; o.mulres = mul;
        o.rfwe = rfwe && !bad; o.dm2rf = dm2rf && !bad; o.hilowe = hilowe && !bad;
        o.wbdata = alu;
        o.excode = !bad ? EXC_NONE : (m.is_load ? EXC_ADEL : EXC_ADES);
        if (c + k + 2 >= NCYC) begin
            n_cmp++; n_bad++;
            $display("FAIL cycle_budget: cycle %0d exceeds model window %0d", c, NCYC);
            $fatal(1, "model window exhausted");
        end
        if (!mem || bad) begin
            exp_out[c+1] = o; exp_full[c+1] = 1'b1;
            @(posedge clk); #1;
        end else begin
            exp_stall[c] = 1'b1;
            for (int j = 1; j <= k; j++) begin
                exp_req[c+j]   = 1'b1;
                exp_we[c+j]    = m.is_store;
                exp_be[c+j]    = be_model(m, alu);
                exp_wdata[c+j] = wdata_model(m, din);
                exp_addr[c+j]  = alu & 32'hFFFF_FFFC;
                exp_stall[c+j] = (j < k);
            end
            o.valid = 1'b1;
            o.wbdata = m.is_load ? load_model(m, alu, rd) : alu;
            exp_out[c+k+1] = o; exp_full[c+k+1] = 1'b1;
            for (int j = 1; j <= k; j++) begin
                @(posedge clk); #1;
                dm_ack   = (j == k);
                dm_rdata = (j == k) ? rd : 32'h5A5A_0000 + j;
            end
            @(posedge clk); #1;
            dm_ack = 1'b0; dm_rdata = '0;
        end
    endtask

    initial begin
        #5;
        check("rst_valid", o_valid, 1'b0);
        check("rst_wbdata", o_wbdata, 32'h0);
        check("rst_excode", o_excode, EXC_NONE);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_stall", stallreq, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        issue(1, OP_NONE, 32'h0000_0011, 32'h0, 1, 0, 0, REG_T0, 64'h0, 0, 32'h0);
        check("add_wbdata", o_wbdata, 32'h11);
        check("add_valid", o_valid, 1'b1);
        issue(0, OP_NONE, 32'h0, 32'h0, 0, 0, 0, REG_ZERO, 64'h0, 0, 32'h0);
        issue(1, OP_LW, 32'h100, 32'h0, 1, 1, 0, REG_T1, 64'h0, 1, 32'hDEAD_BEEF);
        check("lw_wbdata", o_wbdata, 32'hDEAD_BEEF);
        issue(1, OP_LB, 32'h103, 32'h0, 1, 1, 0, REG_T2, 64'h0, 1, 32'h80FF_FFFF);
        check("lb_wbdata", o_wbdata, 32'hFFFF_FF80);
        issue(1, OP_LBU, 32'h103, 32'h0, 1, 1, 0, REG_T3, 64'h0, 2, 32'h80FF_FFFF);
        check("lbu_wbdata", o_wbdata, 32'h0000_0080);
        issue(1, OP_SH, 32'h102, 32'h1234_ABCD, 0, 0, 0, REG_ZERO, 64'h0, 3, 32'h0);
        check("sh_valid", o_valid, 1'b1);
        issue(1, OP_LW, 32'h101, 32'h0, 1, 1, 0, REG_T4, 64'h0, 1, 32'h0);
        check("lw_mis_exc", o_excode, EXC_ADEL);
        check("lw_mis_rfwe", o_rfwe, 1'b0);
        issue(1, OP_SW, 32'h102, 32'h7777_0000, 0, 0, 0, REG_ZERO, 64'h0, 1, 32'h0);
        check("sw_mis_exc", o_excode, EXC_ADES);
        dm_ack = 1'b1;
        issue(1, OP_NONE, 32'h0, 32'h0, 0, 0, 1, REG_ZERO, 64'hFEDC_BA98_7654_3210, 0, 32'h0);
        dm_ack = 1'b0;
        check("mult_mulres", o_mulres, 64'hFEDC_BA98_7654_3210);
        issue(1, OP_LH, 32'h102, 32'h0, 1, 1, 0, REG_S0, 64'h0, 2, 32'h8001_7FFF);
        check("lh_wbdata", o_wbdata, 32'hFFFF_8001);
        issue(1, OP_LHU, 32'h100, 32'h0, 1, 1, 0, REG_S1, 64'h0, 1, 32'h8001_F00F);
        check("lhu_wbdata", o_wbdata, 32'h0000_F00F);
        issue(1, OP_LH, 32'h100, 32'h0, 1, 1, 0, REG_S2, 64'h0, 1, 32'h8001_F00F);
        issue(1, OP_SB, 32'h101, 32'h0000_00A5, 0, 0, 0, REG_ZERO, 64'h0, 2, 32'h0);
        issue(1, OP_SW, 32'h104, 32'hCAFE_F00D, 0, 0, 0, REG_ZERO, 64'h0, 1, 32'h0);
        issue(1, OP_LH, 32'h103, 32'h0, 1, 1, 0, REG_S3, 64'h0, 1, 32'h0);
        issue(1, OP_SH, 32'h101, 32'h0, 0, 0, 0, REG_ZERO, 64'h0, 1, 32'h0);
        issue(0, OP_LW, 32'h200, 32'h0, 1, 1, 0, REG_S4, 64'h0, 1, 32'h0);
        issue(1, OP_NONE, 32'h0000_0055, 32'h0, 1, 0, 0, REG_S5, 64'h1, 0, 32'h0);
        check("pre_rst_wbdata", o_wbdata, 32'h55);

        chk_en = 1'b0;
        i_valid = 1'b1; i_memop = OP_SW; i_alures = 32'h200; i_dmdin = 32'hCAFE_F00D;
        i_rfwe = 1'b0; i_dm2rf = 1'b0; i_hilowe = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req_before", dm_req, 1'b1);
        #3;
        rst_n = 1'b0; i_valid = 1'b0;
        #1;
        check("rst_mid_req", dm_req, 1'b0);
        check("rst_mid_stall", stallreq, 1'b0);
        check("rst_mid_valid", o_valid, 1'b0);
        check("rst_mid_wbdata", o_wbdata, 32'h0);
        check("rst_mid_rfwe", o_rfwe, 1'b0);
        check("rst_mid_mulres", o_mulres, 64'h0);
        check("rst_mid_excode", o_excode, EXC_NONE);
        check("rst_mid_be", dm_be, 4'h0);
        check("rst_mid_addr", dm_addr, 32'h0);
        check("rst_mid_wdata", dm_wdata, 32'h0);
        check("rst_mid_we", dm_we, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req", dm_req, 1'b0);
        chk_en = 1'b1;
        issue(1, OP_NONE, 32'h0000_0099, 32'h0, 1, 0, 0, REG_T5, 64'h0, 0, 32'h0);
        issue(1, OP_LW, 32'h300, 32'h0, 1, 1, 0, REG_T6, 64'h0, 2, 32'h0BAD_CAFE);
        check("post_rst_lw", o_wbdata, 32'h0BAD_CAFE);
        issue(0, OP_NONE, 32'h0, 32'h0, 0, 0, 0, REG_ZERO, 64'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
